// File: rtl/hdma_engine.sv
// ---------------------------------------------------------------------------
// hdma_engine
//
// Block-copy DMA engine. It copies BLOCK_BYTES-byte blocks from any 16-bit
// source address into the 8 KiB VRAM window at DST_BASE. The engine sits on
// the CPU register bus as five byte registers and drives a bus-master port.
// That port is muxed in front of the memory map, the same way as the OAM DMA.
//
// Modes
//   general purpose : every block runs back-to-back with the CPU stalled.
//   hblank          : one block per rising edge of the PPU hblank level. The
//                     CPU runs while the engine waits between blocks.
//
// Register map (offset from BASE_ADDR)
//   0 SRC_HI   1 SRC_LO   2 DST_HI   3 DST_LO   4 CTRL
//   CTRL write (idle) : [6:0] = blocks-1, [7] = mode (0 GP, 1 hblank)
//   CTRL write (busy) : in hblank mode, bit7 = 0 cancels. Otherwise ignored.
//   CTRL read         : {~busy, remaining}. Reads 8'hff once a copy completes.
//
// Configuration
//   HDMA_READBACK_EN  defined     : SRC/DST read back their stored, masked values.
//                     not defined : SRC/DST read as 8'hff.
//
// Ports
//   clockgb      in   1   system clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   address      in   16  CPU bus address
//   indata       in   8   CPU write data
//   outdata      out  8   CPU read data. 8'h00 outside the register window.
//   load         in   1   CPU read strobe
//   store        in   1   CPU write strobe
//   hblank       in   1   PPU hblank level
//   dma_address  out  16  master address
//   dma_indata   in   8   master read data. It is sampled on the edge that ends
//                         the read cycle.
//   dma_outdata  out  8   master write data
//   dma_load     out  1   master read strobe
//   dma_store    out  1   master write strobe
//   dma_active   out  1   engine owns the bus (CPU stalled / muxed out)
// ---------------------------------------------------------------------------
module hdma_engine #(
  parameter logic [15:0] BASE_ADDR   = 16'hff51,
  parameter int          BLOCK_BYTES = 16,
  parameter logic [15:0] DST_BASE    = 16'h8000
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic        hblank,
  output logic [15:0] dma_address,
  input  logic [7:0]  dma_indata,
  output logic [7:0]  dma_outdata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        dma_active
);

  localparam int         BLOCK_LOG2 = $clog2(BLOCK_BYTES);
  // Clears the byte-within-block bits, so addresses stay block aligned.
  localparam logic [7:0] LO_MASK    = ~8'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,  // no copy armed
    ST_RD,    // reading the source byte
    ST_WR,    // writing the byte into VRAM
    ST_WAIT   // hblank mode: between blocks, CPU owns the bus
  } state_t;

  state_t      state_q;
  logic [15:0] src_q;
  logic [12:0] dst_q;
  logic [6:0]  remaining_q;
  logic        hblank_mode_q;
  logic        cancel_q;      // cancel seen during RD, applied after the WR
  logic        hblank_q;

  // ------------------------------------------------------------------
  // CPU register decode
  // ------------------------------------------------------------------
  logic [15:0] reg_off;
  logic        in_range;
  logic        wr_src_hi, wr_src_lo, wr_dst_hi, wr_dst_lo, wr_ctrl;
  logic        cancel_req;
  logic        hblank_rise;
  logic        block_end;
  logic        busy;

  // A 16-bit subtraction wraps, so addresses below BASE_ADDR fall out of range.
  assign reg_off   = address - BASE_ADDR;
  assign in_range  = reg_off < 16'd5;

  assign wr_src_hi = store && in_range && (reg_off[2:0] == 3'd0);
  assign wr_src_lo = store && in_range && (reg_off[2:0] == 3'd1);
  assign wr_dst_hi = store && in_range && (reg_off[2:0] == 3'd2);
  assign wr_dst_lo = store && in_range && (reg_off[2:0] == 3'd3);
  assign wr_ctrl   = store && in_range && (reg_off[2:0] == 3'd4);

  // Only an hblank-mode copy can be stopped. A GP copy ignores CTRL writes.
  assign cancel_req  = wr_ctrl && hblank_mode_q && !indata[7];
  assign hblank_rise = hblank && !hblank_q;

  // The destination is block aligned, so its low bits count bytes in the block.
  assign block_end   = &dst_q[BLOCK_LOG2-1:0];

  // "busy" means a copy is armed. It stays high in WAIT, where the bus is released.
  assign busy        = (state_q != ST_IDLE);

  // ------------------------------------------------------------------
  // Engine state and registers
  // ------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) only. Every
  // register then sees the pre-edge values of the others, however the
  // statements are ordered.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      src_q         <= 16'h0000;
      dst_q         <= 13'h0000;
      remaining_q   <= 7'h7f;
      hblank_mode_q <= 1'b0;
      cancel_q      <= 1'b0;
      hblank_q      <= 1'b0;
      dma_outdata   <= 8'h00;
    end else begin
      hblank_q <= hblank;

      unique case (state_q)
        ST_IDLE: begin
          if (wr_ctrl) begin
            remaining_q   <= indata[6:0];
            hblank_mode_q <= indata[7];
            cancel_q      <= 1'b0;
            // Hblank mode always waits for a fresh rising edge, so a start
            // made while hblank is already high does not fire at once.
            state_q       <= indata[7] ? ST_WAIT : ST_RD;
          end
        end

        ST_WAIT: begin
          if (cancel_req) begin
            state_q <= ST_IDLE;
          end else if (hblank_rise) begin
            state_q <= ST_RD;
          end
        end

        ST_RD: begin
          dma_outdata <= dma_indata;
          state_q     <= ST_WR;
          // Let the byte in flight finish. The cancel is applied at the end of the WR.
          if (cancel_req) begin
            cancel_q <= 1'b1;
          end
        end

        ST_WR: begin
          src_q <= src_q + 16'd1;
          dst_q <= dst_q + 13'd1;
          if (cancel_q || cancel_req) begin
            cancel_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (block_end) begin
            if (remaining_q == 7'd0) begin
              remaining_q <= 7'h7f;
              state_q     <= ST_IDLE;
            end else begin
              remaining_q <= remaining_q - 7'd1;
              state_q     <= hblank_mode_q ? ST_WAIT : ST_RD;
            end
          end else begin
            state_q <= ST_RD;
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      // CPU address writes come after the engine update. If both touch the
      // same register in one cycle, the CPU value is the one kept.
      if (wr_src_hi) begin
        src_q[15:8] <= indata;
      end
      if (wr_src_lo) begin
        src_q[7:0] <= indata & LO_MASK;
      end
      if (wr_dst_hi) begin
        dst_q[12:8] <= indata[4:0];
      end
      if (wr_dst_lo) begin
        dst_q[7:0] <= indata & LO_MASK;
      end
    end
  end

  // ------------------------------------------------------------------
  // Bus-master port (decoded from the registered state)
  // ------------------------------------------------------------------
  assign dma_load   = (state_q == ST_RD);
  assign dma_store  = (state_q == ST_WR);
  assign dma_active = dma_load || dma_store;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    dma_address = 16'h0000;
    unique case (state_q)
      ST_RD:   dma_address = src_q;
      ST_WR:   dma_address = DST_BASE | {3'b000, dst_q};
      default: dma_address = 16'h0000;
    endcase
  end

  // ------------------------------------------------------------------
  // CPU readback
  // ------------------------------------------------------------------
  always_comb begin
    outdata = 8'h00;
    if (load && in_range) begin
      unique case (reg_off[2:0])
`ifdef HDMA_READBACK_EN
        3'd0:    outdata = src_q[15:8];
        3'd1:    outdata = src_q[7:0];
        3'd2:    outdata = {3'b000, dst_q[12:8]};
        3'd3:    outdata = dst_q[7:0];
`else
        3'd0:    outdata = 8'hff;
        3'd1:    outdata = 8'hff;
        3'd2:    outdata = 8'hff;
        3'd3:    outdata = 8'hff;
`endif
        3'd4:    outdata = {~busy, remaining_q};
        default: outdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_hdma_engine.sv
// ---------------------------------------------------------------------------
// tb_hdma_engine
//
// Scoreboard bench for hdma_engine.
//
// Expected values
//   - Each test pushes its expected master writes ({address, data}) and CPU
//     read values into queues when it issues the stimulus.
//   - The expected writes come from a copy model: the byte at src+i goes to
//     DST_BASE | (dst+i mod 8 KiB).
//
// Monitor
//   A separate monitor samples on the falling clock edge.
//   - It pops the write queue whenever dma_store is seen, and compares.
//   - It pops the read queue whenever load is seen, and compares.
//   - It also counts dma_active cycles.
//
// Source memory
//   The master reads from a randomised source memory.
// ---------------------------------------------------------------------------
module tb_hdma_engine;

  localparam logic [15:0] BASE     = 16'hff51;
  localparam int          BB       = 16;
  localparam logic [15:0] DST_BASE = 16'h8000;
  localparam logic [15:0] A_SRC_HI = BASE;
  localparam logic [15:0] A_SRC_LO = BASE + 16'd1;
  localparam logic [15:0] A_DST_HI = BASE + 16'd2;
  localparam logic [15:0] A_DST_LO = BASE + 16'd3;
  localparam logic [15:0] A_CTRL   = BASE + 16'd4;

  logic        clockgb = 1'b0;
  logic        resetn  = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  indata  = 8'h00;
  logic [7:0]  outdata;
  logic        load    = 1'b0;
  logic        store   = 1'b0;
  logic        hblank  = 1'b0;
  logic [15:0] dma_address;
  logic [7:0]  dma_indata;
  logic [7:0]  dma_outdata;
  logic        dma_load, dma_store, dma_active;

  logic [7:0]  mem [0:65535];
  assign dma_indata = mem[dma_address];

  hdma_engine dut (
    .clockgb    (clockgb),
    .resetn     (resetn),
    .address    (address),
    .indata     (indata),
    .outdata    (outdata),
    .load       (load),
    .store      (store),
    .hblank     (hblank),
    .dma_address(dma_address),
    .dma_indata (dma_indata),
    .dma_outdata(dma_outdata),
    .dma_load   (dma_load),
    .dma_store  (dma_store),
    .dma_active (dma_active)
  );

  always #5 clockgb = ~clockgb;

  int          n_checks     = 0;
  int          n_pass       = 0;
  int          active_cycles = 0;
  int          wr_count     = 0;
  int          strobe_err   = 0;
  logic [23:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  string       rd_name_q [$];

`ifdef HDMA_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected register readback: the stored value with readback, 8'hff without.
  function automatic logic [7:0] rb(input logic [7:0] stored);
    return RB ? stored : 8'hff;
  endfunction

  // Copy model: bytes [first, first+count) of a copy from the written SRC/DST.
  task automatic expect_bytes(input logic [15:0] src, input logic [15:0] dst,
                              input int first, input int count);
    logic [15:0] s0;
    logic [12:0] d0;
    logic [15:0] s;
    logic [12:0] d;
    s0 = src & ~16'(BB - 1);
    d0 = dst[12:0] & ~13'(BB - 1);
    for (int i = first; i < first + count; i++) begin
      s = s0 + 16'(i);
      d = d0 + 13'(i);
      exp_wr_q.push_back({DST_BASE | {3'b000, d}, mem[s]});
    end
  endtask

  // Bus tasks start at posedge+1 and return one cycle later at posedge+1.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    address = a; indata = d; store = 1'b1;
    @(posedge clockgb); #1;
    store = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(name);
    address = a; load = 1'b1;
    @(posedge clockgb); #1;
    load = 1'b0;
  endtask

  task automatic set_regs(input logic [15:0] src, input logic [15:0] dst);
    cpu_write(A_SRC_HI, src[15:8]);
    cpu_write(A_SRC_LO, src[7:0]);
    cpu_write(A_DST_HI, dst[15:8]);
    cpu_write(A_DST_LO, dst[7:0]);
  endtask

  task automatic wait_inactive(input string name, input int budget);
    int n;
    n = 0;
    while (dma_active && n < budget) begin
      @(posedge clockgb); #1;
      n++;
    end
    check({name, "_done_in_budget"}, 32'(dma_active), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clockgb);
    #1;
  endtask

  task automatic hblank_pulse();
    hblank = 1'b1;
    wait_cycles(3);
    hblank = 1'b0;
  endtask

  // Monitor: pops and compares whenever the DUT presents a write or a CPU read.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clockgb);
      if (dma_active) active_cycles++;
      if ((dma_load && dma_store) || ((dma_load || dma_store) != dma_active)) strobe_err++;
      if (dma_store) begin
        wr_count++;
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", dma_address, dma_outdata);
        end else begin
          e = exp_wr_q.pop_front();
          check("dma_write", {8'h00, dma_address, dma_outdata}, {8'h00, e});
        end
      end
      if (load) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read: got %h, expected no read", outdata);
        end else begin
          check(rd_name_q.pop_front(), 32'(outdata), 32'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rs, rd;
    int          len;
    int          target;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // ---------------- reset state ----------------
    wait_cycles(3);
    check("rst_active", 32'(dma_active), 0);
    check("rst_load_store", {30'd0, dma_load, dma_store}, 0);
    check("rst_outdata", 32'(dma_outdata), 0);
    resetn = 1'b1;
    wait_cycles(1);
    cpu_read(A_CTRL, 8'hff, "rst_ctrl");
    cpu_read(A_SRC_HI, rb(8'h00), "rst_src_hi");
    cpu_read(BASE - 16'd1, 8'h00, "below_window");
    cpu_read(BASE + 16'd5, 8'h00, "above_window");

    // ---------------- test 1: GP single block ----------------
    set_regs(16'hc000, 16'h8000);
    expect_bytes(16'hc000, 16'h8000, 0, BB);
    active_cycles = 0;
    cpu_write(A_CTRL, 8'h00);
    check("gp_first_cycle_active", {30'd0, dma_active, dma_load}, 32'b11);
    check("gp_first_rd_addr", 32'(dma_address), 32'hc000);
    wait_inactive("gp1", 2 * BB + 10);
    check("gp1_active_cycles", active_cycles, 2 * BB);
    cpu_read(A_CTRL, 8'hff, "gp1_ctrl_after");

    // ---------------- test 2: GP 3 blocks with wraps ----------------
    set_regs(16'hd0f0, 16'h9ff0);
    cpu_read(A_DST_HI, rb(8'h1f), "dst_hi_masked");
    expect_bytes(16'hd0f0, 16'h9ff0, 0, 3 * BB);
    active_cycles = 0;
    cpu_write(A_CTRL, 8'h02);
    cpu_read(A_CTRL, 8'h02, "gp2_ctrl_during");
    wait_inactive("gp2", 6 * BB + 10);
    check("gp2_active_cycles", active_cycles, 6 * BB);
    cpu_read(A_CTRL, 8'hff, "gp2_ctrl_after");

    // ---------------- test 3: HBLANK, 2 blocks, three pulses ----------------
    set_regs(16'ha200, 16'h8400);
    hblank = 1'b1;
    active_cycles = 0;
    cpu_write(A_CTRL, 8'h81);
    wait_cycles(8);
    check("hb_start_while_high_no_xfer", active_cycles, 0);
    cpu_read(A_CTRL, 8'h01, "hb_ctrl_armed");
    hblank = 1'b0;
    wait_cycles(2);
    expect_bytes(16'ha200, 16'h8400, 0, BB);
    hblank_pulse();
    wait_inactive("hb_blk1", 2 * BB + 10);
    check("hb_blk1_active_cycles", active_cycles, 2 * BB);
    wait_cycles(5);
    check("hb_wait_bus_released", 32'(dma_active), 0);
    cpu_read(A_CTRL, 8'h00, "hb_ctrl_between");
    expect_bytes(16'ha200, 16'h8400, BB, BB);
    active_cycles = 0;
    hblank_pulse();
    wait_inactive("hb_blk2", 2 * BB + 10);
    check("hb_blk2_active_cycles", active_cycles, 2 * BB);
    cpu_read(A_CTRL, 8'hff, "hb_ctrl_after");
    active_cycles = 0;
    hblank_pulse();
    wait_cycles(40);
    check("hb_pulse3_no_xfer", active_cycles, 0);

    // ---------------- test 4: HBLANK cancel ----------------
    set_regs(16'hb000, 16'h8800);
    cpu_write(A_CTRL, 8'h83);
    wait_cycles(2);
    expect_bytes(16'hb000, 16'h8800, 0, BB);
    hblank_pulse();
    wait_inactive("cancel_blk1", 2 * BB + 10);
    cpu_read(A_CTRL, 8'h02, "cancel_ctrl_before");
    cpu_write(A_CTRL, 8'h00);
    cpu_read(A_CTRL, 8'h82, "cancel_ctrl_after");
    active_cycles = 0;
    hblank_pulse();
    wait_cycles(40);
    check("cancel_no_further_xfer", active_cycles, 0);

    // ---------------- test 5: reset mid-GP ----------------
    set_regs(16'hc000, 16'h8200);
    expect_bytes(16'hc000, 16'h8200, 0, BB);
    target = wr_count + 5;
    cpu_write(A_CTRL, 8'h00);
    for (int n = 0; n < 40 && wr_count < target; n++) begin
      @(posedge clockgb); #1;
    end
    check("midrst_reached_byte5", wr_count, target);
    #2 resetn = 1'b0;
    #1;
    check("midrst_active", 32'(dma_active), 0);
    check("midrst_load_store", {30'd0, dma_load, dma_store}, 0);
    check("midrst_outdata", 32'(dma_outdata), 0);
    exp_wr_q.delete();
    @(posedge clockgb); @(posedge clockgb); #1;
    resetn = 1'b1;
    wait_cycles(1);
    cpu_read(A_CTRL, 8'hff, "midrst_ctrl");
    cpu_read(A_SRC_LO, rb(8'h00), "midrst_src_lo");

    // ---------------- test 6: masked SRC_LO ----------------
    set_regs(16'hc137, 16'h8100);
    cpu_read(A_SRC_LO, rb(8'h30), "src_lo_masked");
    expect_bytes(16'hc137, 16'h8100, 0, BB);
    cpu_write(A_CTRL, 8'h00);
    check("masked_first_rd_addr", 32'(dma_address), 32'hc130);
    wait_inactive("masked", 2 * BB + 10);

    // ---------------- randomized GP copies ----------------
    for (int t = 0; t < 5; t++) begin
      rs  = {8'($urandom_range(160, 255)), 8'($urandom)};
      rd  = 16'($urandom);
      len = $urandom_range(0, 3);
      set_regs(rs, rd);
      expect_bytes(rs, rd, 0, BB * (len + 1));
      active_cycles = 0;
      cpu_write(A_CTRL, {1'b0, 7'(len)});
      wait_inactive("rand_gp", 2 * BB * (len + 1) + 10);
      check("rand_gp_active_cycles", active_cycles, 2 * BB * (len + 1));
      cpu_read(A_CTRL, 8'hff, "rand_gp_ctrl_after");
    end

    wait_cycles(2);
    check("strobe_rules", strobe_err, 0);
    check("write_queue_drained", exp_wr_q.size(), 0);
    check("read_queue_drained", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
